// File: rtl/mem_port_arbiter.sv
// Single-port DRAM arbiter between the MEM stage and a DMA/debug loader.
// Same-cycle grant, starvation-bounded DMA fairness, burst lock, and read-return routing.
module mem_port_arbiter #(
    parameter  int ADDR_W       = 16,
    parameter  int STARVE_LIMIT = 4,
    localparam int STARVE_W     = $clog2(STARVE_LIMIT + 1)
) (
    input  logic                clk,
    input  logic                rst_n,

    input  logic                cpu_req,
    input  logic [3:0]          cpu_we,
    input  logic [ADDR_W-1:0]   cpu_addr,
    input  logic [31:0]         cpu_wdata,
    output logic                cpu_stall,
    output logic                cpu_rvalid,
    output logic [31:0]         cpu_rdata,

    input  logic                dma_req,
    input  logic                dma_lock,
    input  logic [3:0]          dma_we,
    input  logic [ADDR_W-1:0]   dma_addr,
    input  logic [31:0]         dma_wdata,
    output logic                dma_gnt,
    output logic                dma_rvalid,
    output logic [31:0]         dma_rdata,

    output logic [ADDR_W-1:0]   dram_a,
    output logic [3:0]          dram_we,
    output logic [31:0]         dram_din,
    input  logic [31:0]         dram_spo,

    output logic                dbg_own,
    output logic [STARVE_W-1:0] dbg_starve
);

    // Handshake: a request (cpu_req/dma_req) is a valid that must hold its fields
    // stable until accepted; acceptance is cpu_req && !cpu_stall or dma_gnt in the
    // same cycle, the write commits at that edge, and read data returns one cycle later.

    typedef enum logic {
        FREE     = 1'b0,
        DMA_LOCK = 1'b1
    } own_t;

    localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);

    own_t                own_q;
    own_t                own_d;
    logic [STARVE_W-1:0] starve_q;
    logic [STARVE_W-1:0] starve_d;
    logic                rd_cpu_q;
    logic                rd_dma_q;

    logic                dma_win;
    logic                cpu_gnt;

    // Grant decision; reset gates every grant off so nothing reaches the DRAM.
    always_comb begin
        dma_win   = 1'b0;
        cpu_gnt   = 1'b0;
        cpu_stall = 1'b0;
        if (rst_n) begin
            dma_win   = dma_req && ((own_q == DMA_LOCK) || !cpu_req || (starve_q == STARVE_MAX));
            cpu_gnt   = cpu_req && !dma_win;
            cpu_stall = cpu_req && !cpu_gnt;
        end
    end

    assign dma_gnt = dma_win;

    always_comb begin
        dram_a   = cpu_addr;
        dram_we  = 4'b0000;
        dram_din = cpu_wdata;
        if (dma_win) begin
            dram_a   = dma_addr;
            dram_we  = dma_we;
            dram_din = dma_wdata;
        end else if (cpu_gnt) begin
            dram_we  = cpu_we;
        end
    end

    always_comb begin
        own_d    = own_q;
        starve_d = starve_q;

        if (!dma_req || dma_win) begin
            starve_d = '0;
        end else if (starve_q != STARVE_MAX) begin
            starve_d = starve_q + STARVE_W'(1);
        end

        case (own_q)
            FREE: begin
                if (dma_win && dma_lock) begin
                    own_d = DMA_LOCK;
                end
            end
            DMA_LOCK: begin
                if (!dma_req || (dma_win && !dma_lock)) begin
                    own_d = FREE;
                end
            end
            default: own_d = FREE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            own_q    <= FREE;
            starve_q <= '0;
            rd_cpu_q <= 1'b0;
            rd_dma_q <= 1'b0;
        end else begin
            own_q    <= own_d;
            starve_q <= starve_d;
            rd_cpu_q <= cpu_gnt && (cpu_we == 4'b0000);
            rd_dma_q <= dma_win && (dma_we == 4'b0000);
        end
    end

    // Both requesters see spo; only the one whose read was granted last cycle gets rvalid.
    assign cpu_rvalid = rd_cpu_q;
    assign dma_rvalid = rd_dma_q;
    assign cpu_rdata  = dram_spo;
    assign dma_rdata  = dram_spo;

    assign dbg_own    = own_q;
    assign dbg_starve = starve_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: per-cycle vector table plus hand-written
// sequences for starvation, reset behaviour and reset during a locked burst.
module tb_mem_port_arbiter;

    localparam int ADDR_W       = 16;
    localparam int STARVE_LIMIT = 4;
    localparam int STARVE_W     = $clog2(STARVE_LIMIT + 1);

    logic                clk;
    logic                rst_n;
    logic                cpu_req;
    logic [3:0]          cpu_we;
    logic [ADDR_W-1:0]   cpu_addr;
    logic [31:0]         cpu_wdata;
    logic                cpu_stall;
    logic                cpu_rvalid;
    logic [31:0]         cpu_rdata;
    logic                dma_req;
    logic                dma_lock;
    logic [3:0]          dma_we;
    logic [ADDR_W-1:0]   dma_addr;
    logic [31:0]         dma_wdata;
    logic                dma_gnt;
    logic                dma_rvalid;
    logic [31:0]         dma_rdata;
    logic [ADDR_W-1:0]   dram_a;
    logic [3:0]          dram_we;
    logic [31:0]         dram_din;
    logic [31:0]         dram_spo;
    logic                dbg_own;
    logic [STARVE_W-1:0] dbg_starve;

    mem_port_arbiter #(.ADDR_W(ADDR_W), .STARVE_LIMIT(STARVE_LIMIT)) dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_stall(cpu_stall), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .dma_req(dma_req), .dma_lock(dma_lock), .dma_we(dma_we), .dma_addr(dma_addr),
        .dma_wdata(dma_wdata), .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
        .dram_a(dram_a), .dram_we(dram_we), .dram_din(dram_din), .dram_spo(dram_spo),
        .dbg_own(dbg_own), .dbg_starve(dbg_starve)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation still running at %0t", $time);
        $fatal(1, "timeout");
    end

    // ---------------- DRAM model: byte-write, registered read ----------------
    logic [31:0] mem [0:255];

    always @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (dram_we[b]) mem[dram_a[7:0]][b*8 +: 8] <= dram_din[b*8 +: 8];
        end
        dram_spo <= mem[dram_a[7:0]];
    end

    // ---------------- scoreboard ----------------
    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic        c_req;
        logic [3:0]  c_we;
        logic [15:0] c_addr;
        logic [31:0] c_wd;
        logic        d_req;
        logic        d_lock;
        logic [3:0]  d_we;
        logic [15:0] d_addr;
        logic [31:0] d_wd;
        logic        e_stall;
        logic        e_gnt;
        logic [15:0] e_a;
        logic [3:0]  e_we;
        logic [31:0] e_din;
        logic        e_crv;
        logic        e_drv;
        logic [31:0] e_rdata;
        logic [2:0]  e_starve;
        logic        e_own;
    } vec_t;

    function automatic vec_t mk(
        input logic c_req, input logic [3:0] c_we, input logic [15:0] c_addr, input logic [31:0] c_wd,
        input logic d_req, input logic d_lock, input logic [3:0] d_we, input logic [15:0] d_addr,
        input logic [31:0] d_wd, input logic e_stall, input logic e_gnt, input logic [15:0] e_a,
        input logic [3:0] e_we, input logic [31:0] e_din, input logic e_crv, input logic e_drv,
        input logic [31:0] e_rdata, input logic [2:0] e_starve, input logic e_own);
        vec_t v;
        v.c_req = c_req; v.c_we = c_we; v.c_addr = c_addr; v.c_wd = c_wd;
        v.d_req = d_req; v.d_lock = d_lock; v.d_we = d_we; v.d_addr = d_addr; v.d_wd = d_wd;
        v.e_stall = e_stall; v.e_gnt = e_gnt; v.e_a = e_a; v.e_we = e_we; v.e_din = e_din;
        v.e_crv = e_crv; v.e_drv = e_drv; v.e_rdata = e_rdata; v.e_starve = e_starve; v.e_own = e_own;
        return v;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic drive(input vec_t v);
        cpu_req  = v.c_req;  cpu_we  = v.c_we;  cpu_addr = v.c_addr; cpu_wdata = v.c_wd;
        dma_req  = v.d_req;  dma_lock = v.d_lock; dma_we = v.d_we; dma_addr = v.d_addr; dma_wdata = v.d_wd;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    vec_t tbl[30];

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        mem[8'h10] = 32'hDEADBEEF;
        mem[8'h30] = 32'h11223344;
        mem[8'h40] = 32'h40404040;
        mem[8'h41] = 32'h41414141;
        mem[8'h50] = 32'h50505050;

        //           creq cwe   caddr  cwdata        dreq lk dwe   daddr  dwdata        stl gnt a      we    din           crv drv rdata         stv own
        tbl[0]  = mk(1, 4'h0, 'h10, 32'h0,        1, 0, 4'h0, 'h50, 32'h0,        0, 0, 'h10, 4'h0, 32'h0,        0, 0, 32'h0,        0, 0);
        tbl[1]  = mk(0, 4'h0, 'h10, 32'h0,        0, 0, 4'h0, 'h50, 32'h0,        0, 0, 'h10, 4'h0, 32'h0,        1, 0, 32'hDEADBEEF, 1, 0);
        tbl[2]  = mk(1, 4'h0, 'h10, 32'h0,        0, 0, 4'h0, 'h50, 32'h0,        0, 0, 'h10, 4'h0, 32'h0,        0, 0, 32'h0,        0, 0);
        tbl[3]  = mk(0, 4'h0, 'h10, 32'h0,        0, 0, 4'h0, 'h50, 32'h0,        0, 0, 'h10, 4'h0, 32'h0,        1, 0, 32'hDEADBEEF, 0, 0);
        tbl[4]  = mk(0, 4'h0, 'h30, 32'h0,        1, 0, 4'h3, 'h30, 32'hAABBCCDD, 0, 1, 'h30, 4'h3, 32'hAABBCCDD, 0, 0, 32'h0,        0, 0);
        tbl[5]  = mk(1, 4'h0, 'h30, 32'h0,        0, 0, 4'h0, 'h30, 32'h0,        0, 0, 'h30, 4'h0, 32'h0,        0, 0, 32'h0,        0, 0);
        tbl[6]  = mk(0, 4'h0, 'h30, 32'h0,        0, 0, 4'h0, 'h30, 32'h0,        0, 0, 'h30, 4'h0, 32'h0,        1, 0, 32'h1122CCDD, 0, 0);
        tbl[7]  = mk(1, 4'h0, 'h30, 32'h0,        1, 0, 4'h3, 'h30, 32'h5566EEFF, 0, 0, 'h30, 4'h0, 32'h0,        0, 0, 32'h0,        0, 0);
        tbl[8]  = mk(0, 4'h0, 'h30, 32'h0,        1, 0, 4'h3, 'h30, 32'h5566EEFF, 0, 1, 'h30, 4'h3, 32'h5566EEFF, 1, 0, 32'h1122CCDD, 1, 0);
        tbl[9]  = mk(1, 4'h0, 'h30, 32'h0,        0, 0, 4'h0, 'h30, 32'h0,        0, 0, 'h30, 4'h0, 32'h0,        0, 0, 32'h0,        0, 0);
        tbl[10] = mk(0, 4'h0, 'h30, 32'h0,        0, 0, 4'h0, 'h30, 32'h0,        0, 0, 'h30, 4'h0, 32'h0,        1, 0, 32'h1122EEFF, 0, 0);
        tbl[11] = mk(1, 4'hC, 'h30, 32'h99880000, 0, 0, 4'h0, 'h30, 32'h0,        0, 0, 'h30, 4'hC, 32'h99880000, 0, 0, 32'h0,        0, 0);
        tbl[12] = mk(1, 4'h0, 'h30, 32'h0,        0, 0, 4'h0, 'h30, 32'h0,        0, 0, 'h30, 4'h0, 32'h0,        0, 0, 32'h0,        0, 0);
        tbl[13] = mk(0, 4'h0, 'h30, 32'h0,        0, 0, 4'h0, 'h30, 32'h0,        0, 0, 'h30, 4'h0, 32'h0,        1, 0, 32'h9988EEFF, 0, 0);
        tbl[14] = mk(1, 4'h0, 'h40, 32'h0,        0, 0, 4'h0, 'h41, 32'h0,        0, 0, 'h40, 4'h0, 32'h0,        0, 0, 32'h0,        0, 0);
        tbl[15] = mk(0, 4'h0, 'h40, 32'h0,        1, 0, 4'h0, 'h41, 32'h0,        0, 1, 'h41, 4'h0, 32'h0,        1, 0, 32'h40404040, 0, 0);
        tbl[16] = mk(0, 4'h0, 'h40, 32'h0,        0, 0, 4'h0, 'h41, 32'h0,        0, 0, 'h40, 4'h0, 32'h0,        0, 1, 32'h41414141, 0, 0);
        tbl[17] = mk(0, 4'hF, 'h77, 32'h12345678, 0, 0, 4'h0, 'h41, 32'h0,        0, 0, 'h77, 4'h0, 32'h12345678, 0, 0, 32'h0,        0, 0);
        tbl[18] = mk(1, 4'h0, 'h10, 32'h0,        1, 1, 4'hF, 'h20, 32'hB0B0B0B0, 0, 0, 'h10, 4'h0, 32'h0,        0, 0, 32'h0,        0, 0);
        tbl[19] = mk(1, 4'h0, 'h10, 32'h0,        1, 1, 4'hF, 'h20, 32'hB0B0B0B0, 0, 0, 'h10, 4'h0, 32'h0,        1, 0, 32'hDEADBEEF, 1, 0);
        tbl[20] = mk(1, 4'h0, 'h10, 32'h0,        1, 1, 4'hF, 'h20, 32'hB0B0B0B0, 0, 0, 'h10, 4'h0, 32'h0,        1, 0, 32'hDEADBEEF, 2, 0);
        tbl[21] = mk(1, 4'h0, 'h10, 32'h0,        1, 1, 4'hF, 'h20, 32'hB0B0B0B0, 0, 0, 'h10, 4'h0, 32'h0,        1, 0, 32'hDEADBEEF, 3, 0);
        tbl[22] = mk(1, 4'h0, 'h10, 32'h0,        1, 1, 4'hF, 'h20, 32'hB0B0B0B0, 1, 1, 'h20, 4'hF, 32'hB0B0B0B0, 1, 0, 32'hDEADBEEF, 4, 0);
        tbl[23] = mk(1, 4'h0, 'h10, 32'h0,        1, 1, 4'hF, 'h21, 32'hB1B1B1B1, 1, 1, 'h21, 4'hF, 32'hB1B1B1B1, 0, 0, 32'h0,        0, 1);
        tbl[24] = mk(1, 4'h0, 'h10, 32'h0,        1, 0, 4'hF, 'h22, 32'hB2B2B2B2, 1, 1, 'h22, 4'hF, 32'hB2B2B2B2, 0, 0, 32'h0,        0, 1);
        tbl[25] = mk(1, 4'h0, 'h22, 32'h0,        0, 0, 4'h0, 'h22, 32'h0,        0, 0, 'h22, 4'h0, 32'h0,        0, 0, 32'h0,        0, 0);
        tbl[26] = mk(0, 4'h0, 'h22, 32'h0,        0, 0, 4'h0, 'h22, 32'h0,        0, 0, 'h22, 4'h0, 32'h0,        1, 0, 32'hB2B2B2B2, 0, 0);
        tbl[27] = mk(0, 4'h0, 'h10, 32'h0,        1, 1, 4'hF, 'h23, 32'hC3C3C3C3, 0, 1, 'h23, 4'hF, 32'hC3C3C3C3, 0, 0, 32'h0,        0, 0);
        tbl[28] = mk(1, 4'h0, 'h10, 32'h0,        0, 1, 4'h0, 'h23, 32'h0,        0, 0, 'h10, 4'h0, 32'h0,        0, 0, 32'h0,        0, 1);
        tbl[29] = mk(0, 4'h0, 'h10, 32'h0,        0, 0, 4'h0, 'h23, 32'h0,        0, 0, 'h10, 4'h0, 32'h0,        1, 0, 32'hDEADBEEF, 0, 0);

        // ---- reset with both requesters asking to write ----
        rst_n = 1'b0;
        cpu_req = 1'b1; cpu_we = 4'hF; cpu_addr = 16'h0010; cpu_wdata = 32'h0BADF00D;
        dma_req = 1'b1; dma_lock = 1'b1; dma_we = 4'hF; dma_addr = 16'h0050; dma_wdata = 32'h0BADF00D;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset dma_gnt",    32'(dma_gnt),    32'h0);
        check("reset cpu_stall",  32'(cpu_stall),  32'h0);
        check("reset dram_we",    32'(dram_we),    32'h0);
        check("reset cpu_rvalid", 32'(cpu_rvalid), 32'h0);
        check("reset dma_rvalid", 32'(dma_rvalid), 32'h0);
        check("reset own",        32'(dbg_own),    32'h0);
        check("reset starve",     32'(dbg_starve), 32'h0);
        next_cycle();
        rst_n = 1'b1;

        // ---- table ----
        for (int i = 0; i < 30; i++) begin
            drive(tbl[i]);
            @(negedge clk);
            check($sformatf("v%0d cpu_stall", i),  32'(cpu_stall),  32'(tbl[i].e_stall));
            check($sformatf("v%0d dma_gnt", i),    32'(dma_gnt),    32'(tbl[i].e_gnt));
            check($sformatf("v%0d dram_a", i),     32'(dram_a),     32'(tbl[i].e_a));
            check($sformatf("v%0d dram_we", i),    32'(dram_we),    32'(tbl[i].e_we));
            check($sformatf("v%0d dram_din", i),   dram_din,        tbl[i].e_din);
            check($sformatf("v%0d cpu_rvalid", i), 32'(cpu_rvalid), 32'(tbl[i].e_crv));
            check($sformatf("v%0d dma_rvalid", i), 32'(dma_rvalid), 32'(tbl[i].e_drv));
            check($sformatf("v%0d starve", i),     32'(dbg_starve), 32'(tbl[i].e_starve));
            check($sformatf("v%0d own", i),        32'(dbg_own),    32'(tbl[i].e_own));
            if (tbl[i].e_crv) check($sformatf("v%0d cpu_rdata", i), cpu_rdata, tbl[i].e_rdata);
            if (tbl[i].e_drv) check($sformatf("v%0d dma_rdata", i), dma_rdata, tbl[i].e_rdata);
            next_cycle();
        end

        // ---- starvation: both requesters held; DMA wins every 5th cycle ----
        begin
            logic prev_c;
            logic prev_d;
            logic exp_d;
            prev_c = 1'b0;
            prev_d = 1'b0;
            cpu_req = 1'b1; cpu_we = 4'h0; cpu_addr = 16'h0010; cpu_wdata = 32'h0;
            dma_req = 1'b1; dma_lock = 1'b0; dma_we = 4'h0; dma_addr = 16'h0050; dma_wdata = 32'h0;
            for (int k = 0; k < 11; k++) begin
                if (k == 10) begin
                    cpu_req = 1'b0;
                    dma_req = 1'b0;
                end
                exp_d = (k < 10) && (k % 5 == 4);
                @(negedge clk);
                if (k < 10) begin
                    check($sformatf("starve k%0d dma_gnt", k),   32'(dma_gnt),    32'(exp_d));
                    check($sformatf("starve k%0d cpu_stall", k), 32'(cpu_stall),  32'(exp_d));
                    check($sformatf("starve k%0d count", k),     32'(dbg_starve), 32'(k % 5));
                end
                check($sformatf("starve k%0d cpu_rvalid", k), 32'(cpu_rvalid), 32'(prev_c));
                check($sformatf("starve k%0d dma_rvalid", k), 32'(dma_rvalid), 32'(prev_d));
                if ((prev_c || prev_d) && exp_q.size() > 0) begin
                    check($sformatf("starve k%0d rdata", k), prev_c ? cpu_rdata : dma_rdata, exp_q.pop_front());
                end
                if (k < 10) exp_q.push_back(exp_d ? 32'h50505050 : 32'hDEADBEEF);
                prev_c = (k < 10) && !exp_d;
                prev_d = exp_d;
                next_cycle();
            end
            check("starve queue drained", 32'(exp_q.size()), 32'h0);
        end

        // ---- reset in the middle of a locked DMA read burst ----
        cpu_req = 1'b0; cpu_we = 4'h0; cpu_addr = 16'h0010; cpu_wdata = 32'h0;
        dma_req = 1'b1; dma_lock = 1'b1; dma_we = 4'h0; dma_addr = 16'h0041; dma_wdata = 32'h0;
        @(negedge clk);
        check("burst rd beat0 gnt", 32'(dma_gnt), 32'h1);
        next_cycle();
        cpu_req = 1'b1;
        dma_addr = 16'h0040;
        @(negedge clk);
        check("burst rd beat1 gnt",    32'(dma_gnt),    32'h1);
        check("burst rd beat1 stall",  32'(cpu_stall),  32'h1);
        check("burst rd beat0 rvalid", 32'(dma_rvalid), 32'h1);
        check("burst rd beat0 rdata",  dma_rdata,       32'h41414141);
        next_cycle();
        rst_n = 1'b0;
        @(negedge clk);
        check("midburst rst dma_gnt",   32'(dma_gnt),   32'h0);
        check("midburst rst cpu_stall", 32'(cpu_stall), 32'h0);
        check("midburst rst dram_we",   32'(dram_we),   32'h0);
        next_cycle();
        rst_n = 1'b1;
        dma_addr = 16'h0050;
        @(negedge clk);
        check("post rst own",        32'(dbg_own),    32'h0);
        check("post rst dma_rvalid", 32'(dma_rvalid), 32'h0);
        check("post rst cpu_rvalid", 32'(cpu_rvalid), 32'h0);
        check("post rst cpu_stall",  32'(cpu_stall),  32'h0);
        check("post rst dma_gnt",    32'(dma_gnt),    32'h0);
        next_cycle();
        cpu_req = 1'b0;
        dma_req = 1'b0;
        @(negedge clk);
        check("post rst starve",     32'(dbg_starve), 32'h1);
        check("post rst cpu rvalid", 32'(cpu_rvalid), 32'h1);
        check("post rst cpu rdata",  cpu_rdata,       32'hDEADBEEF);
        check("post rst dma none",   32'(dma_rvalid), 32'h0);
        next_cycle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
